// File: rtl/serializer_fsm.sv
// Parallel-to-serial stage: loads one LENGTH-bit word per din handshake, then emits one bit per dout handshake.
// First bit is visible the cycle after accept, followed by a one-cycle DONE gap; i_ready=0 holds the current bit.
module serializer_fsm #(
  parameter int LENGTH    = 24,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [LENGTH-1:0] iv_din,
  input  logic              i_din_valid,
  output logic              o_ready,
  output logic              o_dout,
  output logic              o_dout_valid,
  input  logic              i_ready,
  output logic              o_last,
  output logic              o_busy
);

  localparam int CW = $clog2(LENGTH) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [LENGTH-1:0] shift_reg_q, shift_reg_d;
  logic [CW-1:0]     counter_q, counter_d;
  logic              ready_int;
  logic              dout_vld_int;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      shift_reg_q <= '0;
      counter_q   <= '0;
    end else begin
      state_q     <= state_d;
      shift_reg_q <= shift_reg_d;
      counter_q   <= counter_d;
    end
  end

  // With i_en low every branch is skipped, so all state simply holds.
  always_comb begin
    state_d     = state_q;
    shift_reg_d = shift_reg_q;
    counter_d   = counter_q;
    if (i_en) begin
      case (state_q)
        IDLE: begin
          if (i_din_valid) begin
            shift_reg_d = iv_din;
            counter_d   = '0;
            state_d     = SHIFT;
          end
        end
        SHIFT: begin
          if (i_ready) begin
            shift_reg_d = LSB_FIRST ? {1'b0, shift_reg_q[LENGTH-1:1]}
                                    : {shift_reg_q[LENGTH-2:0], 1'b0};
            counter_d   = counter_q + CW'(1);
            if (counter_q == LAST_IDX) begin
              state_d = DONE;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    ready_int    = (state_q == IDLE)  & i_en & i_rst_n;
    dout_vld_int = (state_q == SHIFT) & i_en & i_rst_n;
    o_ready      = ready_int;
    o_dout_valid = dout_vld_int;
    o_dout       = i_rst_n & (LSB_FIRST ? shift_reg_q[0] : shift_reg_q[LENGTH-1]);
    o_last       = dout_vld_int & (counter_q == LAST_IDX);
    o_busy       = (state_q != IDLE) & i_rst_n;
  end

endmodule

// File: tb/tb_serializer_fsm.sv
// Directed bench for serializer_fsm: one LSB-first and one MSB-first instance sharing clock, reset, enable and sink ready.
module tb_serializer_fsm;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_en;
  logic        i_ready;

  logic [23:0] l_din;
  logic        l_din_valid, l_ready, l_dout, l_dout_valid, l_last, l_busy;
  logic [23:0] m_din;
  logic        m_din_valid, m_ready, m_dout, m_dout_valid, m_last, m_busy;

  int tests;
  int fails;
  int nbits;

  serializer_fsm #(.LENGTH(24), .LSB_FIRST(1'b1)) u_lsb (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en),
    .iv_din(l_din), .i_din_valid(l_din_valid), .o_ready(l_ready),
    .o_dout(l_dout), .o_dout_valid(l_dout_valid), .i_ready(i_ready),
    .o_last(l_last), .o_busy(l_busy)
  );

  serializer_fsm #(.LENGTH(24), .LSB_FIRST(1'b0)) u_msb (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en),
    .iv_din(m_din), .i_din_valid(m_din_valid), .o_ready(m_ready),
    .o_dout(m_dout), .o_dout_valid(m_dout_valid), .i_ready(i_ready),
    .o_last(m_last), .o_busy(m_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Presents a word for exactly one accept edge; returns one cycle after the edge.
  task automatic send(input bit msb, input logic [23:0] word);
    if (msb) begin m_din = word; m_din_valid = 1'b1; end
    else     begin l_din = word; l_din_valid = 1'b1; end
    i_ready = 1'b1;
    #1;
    check("ready_before_accept", msb ? m_ready : l_ready, 1);
    @(posedge i_clk);
    #1;
    m_din_valid = 1'b0;
    l_din_valid = 1'b0;
    l_din       = 24'h0;
    m_din       = 24'h0;
    check("busy_after_accept", msb ? m_busy : l_busy, 1);
    check("valid_after_accept", msb ? m_dout_valid : l_dout_valid, 1);
  endtask

  // Receives bits, compares each against the bench-computed expected order.
  // bp=1 drives i_ready 1,0,0,1 repeating; gap_at/rst_at trigger after that many bits.
  task automatic rx(input bit msb, input logic [23:0] word, input int bp,
                    input int gap_at, input int rst_at, output int got);
    int       cyc;
    int       idx;
    logic     v, d, l, rdy;
    logic     held_vld, held_bit;
    logic [23:0] w;
    w = word; cyc = 0; idx = 0; held_vld = 1'b0; held_bit = 1'b0;
    while (idx < 24 && cyc < 300) begin
      rdy = (bp == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
      i_ready = rdy;
      #1;
      v = msb ? m_dout_valid : l_dout_valid;
      d = msb ? m_dout : l_dout;
      l = msb ? m_last : l_last;
      check("dout_valid", v, 1);
      if (held_vld) check("dout_hold", d, held_bit);
      held_vld = 1'b0;
      check("dout_bit", d, msb ? w[23 - idx] : w[idx]);
      check("last_flag", l, (idx == 23));
      if (rdy) idx++;
      else begin held_vld = 1'b1; held_bit = d; end
      @(posedge i_clk);
      #1;
      cyc++;
      if (rdy && idx == gap_at) begin
        i_en = 1'b0;
        for (int g = 0; g < 5; g++) begin
          #1;
          check("gap_valid", msb ? m_dout_valid : l_dout_valid, 0);
          check("gap_ready", msb ? m_ready : l_ready, 0);
          step();
        end
        i_en = 1'b1;
      end
      if (rdy && idx == rst_at) begin
        i_rst_n = 1'b0;
        #1;
        check("rst_valid_drop", msb ? m_dout_valid : l_dout_valid, 0);
        break;
      end
    end
    if (cyc >= 300) check("rx_timeout", cyc, 0);
    got = idx;
  endtask

  initial begin
    tests = 0; fails = 0;
    i_rst_n = 1'b0; i_en = 1'b1; i_ready = 1'b1;
    l_din = 24'h0; l_din_valid = 1'b0;
    m_din = 24'h0; m_din_valid = 1'b0;

    // Reset held for three cycles, with a word offered to prove it is ignored.
    l_din = 24'hFFFFFF; l_din_valid = 1'b1;
    for (int r = 0; r < 3; r++) begin
      step();
      check("rst_ready", l_ready, 0);
      check("rst_valid", l_dout_valid, 0);
      check("rst_last", l_last, 0);
      check("rst_busy", l_busy, 0);
      check("rst_dout", l_dout, 0);
    end
    l_din_valid = 1'b0; l_din = 24'h0;
    i_rst_n = 1'b1;
    #1;
    check("ready_after_release", l_ready, 1);
    check("busy_after_release", l_busy, 0);
    step();

    // Basic LSB-first word, sink always ready, then DONE gap timing.
    send(1'b0, 24'hA5F00F);
    rx(1'b0, 24'hA5F00F, 0, -1, -1, nbits);
    check("basic_count", nbits, 24);
    check("done_ready", l_ready, 0);
    check("done_busy", l_busy, 1);
    check("done_valid", l_dout_valid, 0);
    step();
    check("ready_return", l_ready, 1);
    check("idle_busy", l_busy, 0);

    // Backpressure pattern 1,0,0,1.
    send(1'b0, 24'hA5F00F);
    rx(1'b0, 24'hA5F00F, 1, -1, -1, nbits);
    check("bp_count", nbits, 24);
    i_ready = 1'b1;
    step();
    check("bp_ready_return", l_ready, 1);

    // MSB-first instance.
    send(1'b1, 24'h800001);
    rx(1'b1, 24'h800001, 0, -1, -1, nbits);
    check("msb_count", nbits, 24);
    step();
    check("msb_ready_return", m_ready, 1);

    // Enable drop for five cycles after bit 10.
    send(1'b0, 24'h5A3C96);
    rx(1'b0, 24'h5A3C96, 0, 10, -1, nbits);
    check("gap_count", nbits, 24);
    step();
    check("gap_ready_return", l_ready, 1);

    // Reset after bit 7, then a fresh word must start from its own bit 0.
    send(1'b0, 24'hA5F00F);
    rx(1'b0, 24'hA5F00F, 0, -1, 7, nbits);
    check("rst_mid_count", nbits, 7);
    step();
    check("rst_mid_valid", l_dout_valid, 0);
    check("rst_mid_busy", l_busy, 0);
    step();
    i_rst_n = 1'b1;
    #1;
    check("rst_mid_ready", l_ready, 1);
    step();
    send(1'b0, 24'h000003);
    rx(1'b0, 24'h000003, 0, -1, -1, nbits);
    check("post_rst_count", nbits, 24);
    step();
    check("post_rst_ready", l_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
